// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: function and error codes,
// FSM state encoding, default widths and the divide-by-zero detection helper.
package alu_op_sequencer_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 8;

    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_MUL = 2'b10;
    localparam logic [1:0] FUN_DIV = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } seq_state_e;

    function automatic logic is_div_zero(input logic [1:0] fun, input logic b_is_zero);
        return (fun == FUN_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_wait_timer.sv
// Clear/enable wait counter; expired_o flags the last permitted wait cycle (TIMEOUT-1).
module alu_op_sequencer_wait_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == LAST);

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the signed arithmetic unit: accepts one command, pulses the
// unit enable, waits for the result flag (with timeout) and returns the result on a response port.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int          DATA_W        = DATA_W_DEF,
    parameter int          TIMEOUT       = TIMEOUT_DEF,
    parameter logic [15:0] OPS_RESET_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_fun,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              arith_enable,
    output logic [1:0]        alu_fun,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] arith_out,
    input  logic              arith_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    output logic [15:0]       ops_done
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic              cmd_ready_q;
    logic              arith_enable_q;
    logic              rsp_valid_q;
    logic              div0_q;
    logic [1:0]        alu_fun_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_err_q;
    logic [15:0]       ops_done_q;

    logic accept_s;
    logic rsp_fire_s;
    logic wait_s;
    logic expired_s;

    assign accept_s   = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    assign rsp_fire_s = rsp_valid_q && rsp_ready;
    assign wait_s     = (state_q == ST_WAIT);

    // The counter sits at zero outside WAIT, so every WAIT entry starts a fresh timeout window.
    alu_op_sequencer_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst),
        .clr_i     (!wait_s),
        .en_i      (wait_s && !arith_flag),
        .expired_o (expired_s)
    );

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_ISSUE;
                else          state_d = ST_IDLE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (arith_flag || expired_s) state_d = ST_RESP;
                else                         state_d = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_fire_s) state_d = ST_IDLE;
                else            state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered handshake outputs, operand and response capture, completion count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cmd_ready_q    <= 1'b0;
            arith_enable_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            div0_q         <= 1'b0;
            alu_fun_q      <= 2'b00;
            op_a_q         <= {DATA_W{1'b0}};
            op_b_q         <= {DATA_W{1'b0}};
            rsp_data_q     <= {DATA_W{1'b0}};
            rsp_err_q      <= ERR_OK;
            ops_done_q     <= OPS_RESET_VAL;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= (state_d == ST_IDLE);
            arith_enable_q <= (state_d == ST_ISSUE);
            rsp_valid_q    <= (state_d == ST_RESP);
            if (accept_s) begin
                alu_fun_q <= cmd_fun;
                op_a_q    <= cmd_a;
                op_b_q    <= cmd_b;
                div0_q    <= is_div_zero(cmd_fun, cmd_b == {DATA_W{1'b0}});
            end
            // A flag arriving on the expiry cycle still counts as a normal completion.
            if (wait_s && arith_flag) begin
                rsp_data_q <= arith_out;
                rsp_err_q  <= div0_q ? ERR_DIV0 : ERR_OK;
            end else if (wait_s && expired_s) begin
                rsp_data_q <= {DATA_W{1'b0}};
                rsp_err_q  <= ERR_TIMEOUT;
            end
            if (rsp_fire_s) begin
                ops_done_q <= ops_done_q + 16'd1;
            end
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign arith_enable = arith_enable_q;
    assign alu_fun      = alu_fun_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign ops_done     = ops_done_q;

endmodule
